// File: rtl/ps2_keyboard_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_decoder_pkg
// Shared constants and types for the PS/2 keyboard decoder:
//   - PS/2 Set-2 prefix bytes and the keyboard reset command
//   - Hack keyboard codes for the non-printing keys
//   - state encodings for the init sequencer and the scan-code decoder
//   - letter_code(): case selection for letters
// Optional build macro: PS2_LOWERCASE_EN -- unshifted letters become 97-122
// instead of the Hack-standard 65-90.
// ---------------------------------------------------------------------------
package ps2_keyboard_decoder_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_PAUSE  = 8'hE1;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] CMD_RESET = 8'hFF;

   localparam logic [7:0] KEY_NEWLINE   = 8'd128;
   localparam logic [7:0] KEY_BACKSPACE = 8'd129;
   localparam logic [7:0] KEY_LEFT      = 8'd130;
   localparam logic [7:0] KEY_UP        = 8'd131;
   localparam logic [7:0] KEY_RIGHT     = 8'd132;
   localparam logic [7:0] KEY_DOWN      = 8'd133;
   localparam logic [7:0] KEY_HOME      = 8'd134;
   localparam logic [7:0] KEY_END       = 8'd135;
   localparam logic [7:0] KEY_PGUP      = 8'd136;
   localparam logic [7:0] KEY_PGDN      = 8'd137;
   localparam logic [7:0] KEY_INSERT    = 8'd138;
   localparam logic [7:0] KEY_DELETE    = 8'd139;
   localparam logic [7:0] KEY_ESC       = 8'd140;
   localparam logic [7:0] KEY_F1        = 8'd141;
   localparam logic [7:0] KEY_F2        = 8'd142;
   localparam logic [7:0] KEY_F3        = 8'd143;
   localparam logic [7:0] KEY_F4        = 8'd144;
   localparam logic [7:0] KEY_F5        = 8'd145;
   localparam logic [7:0] KEY_F6        = 8'd146;
   localparam logic [7:0] KEY_F7        = 8'd147;
   localparam logic [7:0] KEY_F8        = 8'd148;
   localparam logic [7:0] KEY_F9        = 8'd149;
   localparam logic [7:0] KEY_F10       = 8'd150;
   localparam logic [7:0] KEY_F11       = 8'd151;
   localparam logic [7:0] KEY_F12       = 8'd152;

   // Offset added to an uppercase letter when no shift key is held.
`ifdef PS2_LOWERCASE_EN
   localparam logic [7:0] LOWER_OFFSET = 8'd32;
`else
   localparam logic [7:0] LOWER_OFFSET = 8'd0;
`endif

   // Init sequencer: wait after reset, send 0xFF once, then stay done.
   typedef enum logic [1:0] {
      S_INIT_WAIT,
      S_INIT_SEND,
      S_INIT_DONE
   } init_state_t;

   // Scan-code decoder: tracks the prefix bytes of the current sequence.
   typedef enum logic [2:0] {
      S_IDLE,
      S_EXT,
      S_BREAK,
      S_EXT_BREAK,
      S_SKIP
   } dec_state_t;

   function automatic logic [7:0] letter_code(input logic [7:0] upper, input logic shift);
      return shift ? upper : (upper + LOWER_OFFSET);
   endfunction

   // Keyboard responses (ACK, BAT ok, echo, resend, errors) carry no key.
   function automatic logic is_response_byte(input logic [7:0] b);
      return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
             (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
   endfunction

endpackage

// File: rtl/ps2_keyboard_decoder_scancode_map.sv
// ---------------------------------------------------------------------------
// ps2_scancode_map
// Combinational PS/2 Set-2 scan code -> Hack key code lookup (US layout).
// Ports:
//   i_extended  in  1  byte was preceded by the E0 prefix
//   i_shift     in  1  a shift key is held
//   i_byte      in  8  scan-code byte
//   o_valid     out 1  the key has a Hack code
//   o_code      out 8  Hack key code (0 when o_valid=0)
// Optional build macro: PS2_LOWERCASE_EN (letter case, via letter_code()).
// ---------------------------------------------------------------------------
module ps2_scancode_map
   import ps2_keyboard_decoder_pkg::*;
(
   input  logic       i_extended,
   input  logic       i_shift,
   input  logic [7:0] i_byte,
   output logic       o_valid,
   output logic [7:0] o_code
);

   always_comb begin
      o_valid = 1'b1;
      o_code  = 8'd0;
      if (i_extended) begin
         case (i_byte)
            8'h5A:   o_code = KEY_NEWLINE;
            8'h6B:   o_code = KEY_LEFT;
            8'h75:   o_code = KEY_UP;
            8'h74:   o_code = KEY_RIGHT;
            8'h72:   o_code = KEY_DOWN;
            8'h6C:   o_code = KEY_HOME;
            8'h69:   o_code = KEY_END;
            8'h7D:   o_code = KEY_PGUP;
            8'h7A:   o_code = KEY_PGDN;
            8'h70:   o_code = KEY_INSERT;
            8'h71:   o_code = KEY_DELETE;
            default: o_valid = 1'b0;
         endcase
      end else begin
         case (i_byte)
            8'h1C:   o_code = letter_code(8'd65, i_shift);  // A
            8'h32:   o_code = letter_code(8'd66, i_shift);
            8'h21:   o_code = letter_code(8'd67, i_shift);
            8'h23:   o_code = letter_code(8'd68, i_shift);
            8'h24:   o_code = letter_code(8'd69, i_shift);
            8'h2B:   o_code = letter_code(8'd70, i_shift);
            8'h34:   o_code = letter_code(8'd71, i_shift);
            8'h33:   o_code = letter_code(8'd72, i_shift);
            8'h43:   o_code = letter_code(8'd73, i_shift);
            8'h3B:   o_code = letter_code(8'd74, i_shift);
            8'h42:   o_code = letter_code(8'd75, i_shift);
            8'h4B:   o_code = letter_code(8'd76, i_shift);
            8'h3A:   o_code = letter_code(8'd77, i_shift);
            8'h31:   o_code = letter_code(8'd78, i_shift);
            8'h44:   o_code = letter_code(8'd79, i_shift);
            8'h4D:   o_code = letter_code(8'd80, i_shift);
            8'h15:   o_code = letter_code(8'd81, i_shift);
            8'h2D:   o_code = letter_code(8'd82, i_shift);
            8'h1B:   o_code = letter_code(8'd83, i_shift);
            8'h2C:   o_code = letter_code(8'd84, i_shift);
            8'h3C:   o_code = letter_code(8'd85, i_shift);
            8'h2A:   o_code = letter_code(8'd86, i_shift);
            8'h1D:   o_code = letter_code(8'd87, i_shift);
            8'h22:   o_code = letter_code(8'd88, i_shift);
            8'h35:   o_code = letter_code(8'd89, i_shift);
            8'h1A:   o_code = letter_code(8'd90, i_shift);  // Z
            8'h45:   o_code = i_shift ? 8'd41  : 8'd48;     // ) 0
            8'h16:   o_code = i_shift ? 8'd33  : 8'd49;     // ! 1
            8'h1E:   o_code = i_shift ? 8'd64  : 8'd50;     // @ 2
            8'h26:   o_code = i_shift ? 8'd35  : 8'd51;     // # 3
            8'h25:   o_code = i_shift ? 8'd36  : 8'd52;     // $ 4
            8'h2E:   o_code = i_shift ? 8'd37  : 8'd53;     // % 5
            8'h36:   o_code = i_shift ? 8'd94  : 8'd54;     // ^ 6
            8'h3D:   o_code = i_shift ? 8'd38  : 8'd55;     // & 7
            8'h3E:   o_code = i_shift ? 8'd42  : 8'd56;     // * 8
            8'h46:   o_code = i_shift ? 8'd40  : 8'd57;     // ( 9
            8'h0E:   o_code = i_shift ? 8'd126 : 8'd96;     // ~ `
            8'h4E:   o_code = i_shift ? 8'd95  : 8'd45;     // _ -
            8'h55:   o_code = i_shift ? 8'd43  : 8'd61;     // + =
            8'h5D:   o_code = i_shift ? 8'd124 : 8'd92;     // | backslash
            8'h54:   o_code = i_shift ? 8'd123 : 8'd91;     // { [
            8'h5B:   o_code = i_shift ? 8'd125 : 8'd93;     // } ]
            8'h4C:   o_code = i_shift ? 8'd58  : 8'd59;     // : ;
            8'h52:   o_code = i_shift ? 8'd34  : 8'd39;     // " '
            8'h41:   o_code = i_shift ? 8'd60  : 8'd44;     // < ,
            8'h49:   o_code = i_shift ? 8'd62  : 8'd46;     // > .
            8'h4A:   o_code = i_shift ? 8'd63  : 8'd47;     // ? /
            8'h29:   o_code = 8'd32;
            8'h5A:   o_code = KEY_NEWLINE;
            8'h66:   o_code = KEY_BACKSPACE;
            8'h76:   o_code = KEY_ESC;
            8'h05:   o_code = KEY_F1;
            8'h06:   o_code = KEY_F2;
            8'h04:   o_code = KEY_F3;
            8'h0C:   o_code = KEY_F4;
            8'h03:   o_code = KEY_F5;
            8'h0B:   o_code = KEY_F6;
            8'h83:   o_code = KEY_F7;
            8'h0A:   o_code = KEY_F8;
            8'h01:   o_code = KEY_F9;
            8'h09:   o_code = KEY_F10;
            8'h78:   o_code = KEY_F11;
            8'h07:   o_code = KEY_F12;
            default: o_valid = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_decoder
// Turns received PS/2 Set-2 scan-code bytes into the Hack KBD value and sends
// the keyboard reset command (0xFF) once, INIT_DELAY cycles after reset.
// Ports:
//   clk          in  1   system clock (12 MHz)
//   reset        in  1   synchronous active-high reset
//   ps2_read     in  1   one-cycle strobe, ps2_rx_data valid
//   ps2_rx_data  in  8   received byte
//   ps2_busy     in  1   receiver/transmitter not idle
//   ps2_write    out 1   one-cycle transmit request
//   ps2_tx_data  out 8   byte to transmit (always 0xFF)
//   key_code     out 16  Hack key code, 0 when no key held
// Optional build macro: PS2_LOWERCASE_EN (lowercase letters when unshifted).
// ---------------------------------------------------------------------------
module ps2_keyboard_decoder
   import ps2_keyboard_decoder_pkg::*;
#(
   parameter logic [23:0] INIT_DELAY = 24'd6000000,
   parameter logic [2:0]  PAUSE_SKIP = 3'd7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_read,
   input  logic [7:0]  ps2_rx_data,
   input  logic        ps2_busy,
   output logic        ps2_write,
   output logic [7:0]  ps2_tx_data,
   output logic [15:0] key_code
);

   init_state_t r_init_state, w_init_state_next;
   logic [23:0] r_init_cnt,   w_init_cnt_next;
   dec_state_t  r_dec_state,  w_dec_state_next;
   logic [2:0]  r_skip_cnt,   w_skip_cnt_next;
   logic        r_shift_l,    w_shift_l_next;
   logic        r_shift_r,    w_shift_r_next;
   logic [7:0]  r_key_code,   w_key_code_next;

   logic        w_write;
   logic        w_extended;
   logic        w_make;
   logic        w_break;
   logic        w_is_shift_byte;
   logic        w_map_valid;
   logic [7:0]  w_map_code;

   ps2_scancode_map u_map (
      .i_extended (w_extended),
      .i_shift    (r_shift_l | r_shift_r),
      .i_byte     (ps2_rx_data),
      .o_valid    (w_map_valid),
      .o_code     (w_map_code)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_init_state <= S_INIT_WAIT;
         r_init_cnt   <= 24'd0;
         r_dec_state  <= S_IDLE;
         r_skip_cnt   <= 3'd0;
         r_shift_l    <= 1'b0;
         r_shift_r    <= 1'b0;
         r_key_code   <= 8'd0;
      end else begin
         r_init_state <= w_init_state_next;
         r_init_cnt   <= w_init_cnt_next;
         r_dec_state  <= w_dec_state_next;
         r_skip_cnt   <= w_skip_cnt_next;
         r_shift_l    <= w_shift_l_next;
         r_shift_r    <= w_shift_r_next;
         r_key_code   <= w_key_code_next;
      end
   end

   // Init sequencer runs independently of decoding, so bytes arriving while
   // it waits are still decoded.
   always_comb begin
      w_init_state_next = r_init_state;
      w_init_cnt_next   = r_init_cnt;
      w_write           = 1'b0;
      case (r_init_state)
         S_INIT_WAIT: begin
            if (r_init_cnt >= INIT_DELAY - 24'd1) begin
               w_init_state_next = S_INIT_SEND;
            end else begin
               w_init_cnt_next = r_init_cnt + 24'd1;
            end
         end
         S_INIT_SEND: begin
            if (!ps2_busy) begin
               w_write           = 1'b1;
               w_init_state_next = S_INIT_DONE;
            end
         end
         default: ;
      endcase
   end

   // Prefix tracking: decides whether this strobe completes a make or break.
   always_comb begin
      w_dec_state_next = r_dec_state;
      w_skip_cnt_next  = r_skip_cnt;
      w_extended       = 1'b0;
      w_make           = 1'b0;
      w_break          = 1'b0;
      case (r_dec_state)
         S_IDLE: begin
            if (ps2_read) begin
               if (ps2_rx_data == SC_EXT) begin
                  w_dec_state_next = S_EXT;
               end else if (ps2_rx_data == SC_BREAK) begin
                  w_dec_state_next = S_BREAK;
               end else if (ps2_rx_data == SC_PAUSE) begin
                  w_dec_state_next = S_SKIP;
                  w_skip_cnt_next  = PAUSE_SKIP;
               end else if (!is_response_byte(ps2_rx_data)) begin
                  w_make = 1'b1;
               end
            end
         end
         S_EXT: begin
            w_extended = 1'b1;
            if (ps2_read) begin
               if (ps2_rx_data == SC_BREAK) begin
                  w_dec_state_next = S_EXT_BREAK;
               end else begin
                  w_make           = 1'b1;
                  w_dec_state_next = S_IDLE;
               end
            end
         end
         S_BREAK: begin
            if (ps2_read) begin
               w_break          = 1'b1;
               w_dec_state_next = S_IDLE;
            end
         end
         S_EXT_BREAK: begin
            w_extended = 1'b1;
            if (ps2_read) begin
               w_break          = 1'b1;
               w_dec_state_next = S_IDLE;
            end
         end
         S_SKIP: begin
            if (ps2_read) begin
               w_skip_cnt_next = r_skip_cnt - 3'd1;
               if (r_skip_cnt <= 3'd1) begin
                  w_dec_state_next = S_IDLE;
               end
            end
         end
         default: w_dec_state_next = S_IDLE;
      endcase
   end

   assign w_is_shift_byte = (ps2_rx_data == SC_LSHIFT) || (ps2_rx_data == SC_RSHIFT);

   // Apply a completed make/break. Extended shift codes are the "fake shift"
   // bytes some keys emit and must not touch the real shift flags.
   always_comb begin
      w_shift_l_next  = r_shift_l;
      w_shift_r_next  = r_shift_r;
      w_key_code_next = r_key_code;
      if (w_make || w_break) begin
         if (w_is_shift_byte) begin
            if (!w_extended) begin
               if (ps2_rx_data == SC_LSHIFT) begin
                  w_shift_l_next = w_make;
               end else begin
                  w_shift_r_next = w_make;
               end
            end
         end else if (w_map_valid) begin
            if (w_make) begin
               w_key_code_next = w_map_code;
            end else if (w_map_code == r_key_code) begin
               // Only releasing the most recently pressed key clears it.
               w_key_code_next = 8'd0;
            end
         end
      end
   end

   assign ps2_write   = w_write;
   assign ps2_tx_data = CMD_RESET;
   assign key_code    = {8'd0, r_key_code};

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
module tb_ps2_keyboard_decoder;

   localparam logic [23:0] T_INIT = 24'd40;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_read = 1'b0;
   logic [7:0]  ps2_rx_data = 8'd0;
   logic        ps2_busy = 1'b0;
   wire         ps2_write;
   wire  [7:0]  ps2_tx_data;
   wire  [15:0] key_code;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   typedef struct {
      logic [7:0]  data;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[$];

   ps2_keyboard_decoder #(.INIT_DELAY(T_INIT), .PAUSE_SKIP(3'd7)) dut (
      .clk         (clk),
      .reset       (reset),
      .ps2_read    (ps2_read),
      .ps2_rx_data (ps2_rx_data),
      .ps2_busy    (ps2_busy),
      .ps2_write   (ps2_write),
      .ps2_tx_data (ps2_tx_data),
      .key_code    (key_code)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Every write pulse must carry 0xFF and never overlap busy.
   always @(negedge clk) begin
      if (ps2_write === 1'b1) begin
         pulses++;
         checks++;
         if (ps2_busy !== 1'b0 || ps2_tx_data !== 8'hFF) begin
            errors++;
            $display("FAIL write_pulse busy=%0b tx=%h required busy=0 tx=ff", ps2_busy, ps2_tx_data);
         end
      end
   end

   // Unshifted letter code for the current build.
   function automatic logic [15:0] lt(input logic [7:0] up);
`ifdef PS2_LOWERCASE_EN
      return {8'd0, up + 8'd32};
`else
      return {8'd0, up};
`endif
   endfunction

   task automatic add(input logic [7:0] b, input logic [15:0] e);
      vec_t v;
      v.data = b;
      v.exp  = e;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, act, exp);
      end
   endtask

   // Strobe one byte; key_code must reflect it right after the next edge.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      ps2_read    = 1'b1;
      ps2_rx_data = b;
      @(posedge clk);
      #1;
      ps2_read = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int p0;
      int first;

      // ---- reset state and init command with receiver idle ----
      do_reset();
      check("reset_key_code", key_code, 16'd0);
      check("reset_write", {15'd0, ps2_write}, 16'd0);
      check("tx_data", {8'd0, ps2_tx_data}, 16'h00FF);
      p0 = pulses;
      first = -1;
      for (int c = 1; c <= int'(T_INIT) + 40; c++) begin
         @(negedge clk);
         if (ps2_write === 1'b1 && first < 0) first = c;
      end
      checks++;
      if (first < int'(T_INIT) - 1 || first > int'(T_INIT) + 1) begin
         errors++;
         $display("FAIL init_timing got cycle %0d required %0d", first, T_INIT);
      end
      $display("init pulse at cycle %0d", first);
      check("init_pulse_count", 16'(pulses - p0), 16'd1);

      // ---- init command held off by busy ----
      ps2_busy = 1'b1;
      do_reset();
      p0 = pulses;
      repeat (int'(T_INIT) + 100) @(negedge clk);
      check("busy_hold_no_pulse", 16'(pulses - p0), 16'd0);
      @(posedge clk);
      #1 ps2_busy = 1'b0;
      @(negedge clk);
      check("busy_release_write", {15'd0, ps2_write}, 16'd1);
      repeat (10) @(negedge clk);
      check("busy_pulse_count", 16'(pulses - p0), 16'd1);

      // ---- reset mid-sequence drops key and E0 prefix; decode during init wait ----
      send_byte(8'h1C);
      check("pre_reset_key", key_code, lt(8'd65));
      send_byte(8'hE0);
      do_reset();
      check("reset_clears_key", key_code, 16'd0);
      send_byte(8'h75);
      check("reset_drops_prefix", key_code, 16'd0);
      send_byte(8'h1C);
      check("decode_in_init_wait", key_code, lt(8'd65));
      send_byte(8'hF0);
      send_byte(8'h1C);
      check("decode_in_init_break", key_code, 16'd0);
      repeat (int'(T_INIT) + 10) @(negedge clk);

      // ---- vector table ----
      add(8'h1C, lt(8'd65)); add(8'hF0, lt(8'd65)); add(8'h1C, 16'd0);
      // shift + 1 -> '!', then shift released clears flag
      add(8'h12, 16'd0); add(8'h16, 16'd33); add(8'hF0, 16'd33); add(8'h16, 16'd0);
      add(8'hF0, 16'd0); add(8'h12, 16'd0);
      add(8'h16, 16'd49); add(8'hF0, 16'd49); add(8'h16, 16'd0);
      // up arrow
      add(8'hE0, 16'd0); add(8'h75, 16'd131); add(8'hE0, 16'd131); add(8'hF0, 16'd131); add(8'h75, 16'd0);
      // shift held, fake shift and print screen do not disturb it
      add(8'h12, 16'd0); add(8'hE0, 16'd0); add(8'h12, 16'd0); add(8'hE0, 16'd0); add(8'h7C, 16'd0);
      add(8'h16, 16'd33); add(8'hF0, 16'd33); add(8'h16, 16'd0); add(8'hF0, 16'd0); add(8'h12, 16'd0);
      // last pressed wins
      add(8'h1C, lt(8'd65)); add(8'h32, lt(8'd66)); add(8'hF0, lt(8'd66)); add(8'h1C, lt(8'd66));
      add(8'hF0, lt(8'd66)); add(8'h32, 16'd0);
      // pause sequence while space held, then response byte, then release
      add(8'h29, 16'd32); add(8'hE1, 16'd32); add(8'h14, 16'd32); add(8'h77, 16'd32); add(8'hE1, 16'd32);
      add(8'hF0, 16'd32); add(8'h14, 16'd32); add(8'hF0, 16'd32); add(8'h77, 16'd32);
      add(8'hFA, 16'd32); add(8'hF0, 16'd32); add(8'h29, 16'd0);
      // pause sequence from idle, then space
      add(8'hE1, 16'd0); add(8'h14, 16'd0); add(8'h77, 16'd0); add(8'hE1, 16'd0);
      add(8'hF0, 16'd0); add(8'h14, 16'd0); add(8'hF0, 16'd0); add(8'h77, 16'd0);
      add(8'h29, 16'd32); add(8'hF0, 16'd32); add(8'h29, 16'd0);
      // keypad enter, esc, F12
      add(8'hE0, 16'd0); add(8'h5A, 16'd128); add(8'hE0, 16'd128); add(8'hF0, 16'd128); add(8'h5A, 16'd0);
      add(8'h76, 16'd140); add(8'hF0, 16'd140); add(8'h76, 16'd0);
      add(8'h07, 16'd152); add(8'hF0, 16'd152); add(8'h07, 16'd0);
      // backspace then left arrow
      add(8'h66, 16'd129); add(8'hE0, 16'd129); add(8'h6B, 16'd130); add(8'hF0, 16'd130);
      add(8'h66, 16'd130); add(8'hE0, 16'd130); add(8'hF0, 16'd130); add(8'h6B, 16'd0);
      // right shift + A is uppercase in both builds; flag clears on release
      add(8'h59, 16'd0); add(8'h1C, 16'd65); add(8'hF0, 16'd65); add(8'h1C, 16'd0);
      add(8'hF0, 16'd0); add(8'h59, 16'd0);
      add(8'h1C, lt(8'd65)); add(8'hF0, lt(8'd65)); add(8'h1C, 16'd0);
      // digit zero, shifted quote
      add(8'h45, 16'd48); add(8'hF0, 16'd48); add(8'h45, 16'd0);
      add(8'h12, 16'd0); add(8'h52, 16'd34); add(8'hF0, 16'd34); add(8'h52, 16'd0);
      add(8'hF0, 16'd0); add(8'h12, 16'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         send_byte(vecs[i].data);
         $display("vec %0d byte %h key_code %0d required %0d", i, vecs[i].data, key_code, vecs[i].exp);
         check($sformatf("vec%0d_byte_%h", i, vecs[i].data), key_code, vecs[i].exp);
      end

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
